spi_tft_stream_tx: RTL

Parametrised, buffered SPI master transmitter for the TFT sub-peripheral. It is the next generation of the fixed 16-bit serializer. Words are accepted over a valid/ready stream into an internal FIFO and shifted out MSB- or LSB-first on an SCK generated by a programmable divider. Each word carries its own data/command (DC) flag, and chip select stays asserted across back-to-back words. The block sits between the pixel/command sequencer and the TFT pins.

---
 rtl/spi_tft_pkg.sv | 18 +
 rtl/spi_tft_fifo.sv | 59 +++++
 rtl/spi_tft_stream_tx.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/spi_tft_pkg.sv
// Shared types and helpers for the TFT SPI stream transmitter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package spi_tft_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_SHIFT = 2'd2,
        ST_HOLD  = 2'd3
    } state_e;

    // Counter width able to hold 0..n-1; never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/spi_tft_fifo.sv
// Synchronous FIFO of {dc, data} entries with occupancy output.
// Latency: a word written in cycle N is first readable in cycle N+1 (no fall-through).
// Backpressure: wr_rdy low while full; a write offered while full is ignored.
// Ports: clk/reset, wr_vld/wr_dat/wr_rdy (push side), rd_en/rd_vld/rd_dat (pop side), level.
module spi_tft_fifo
    import spi_tft_pkg::*;
#(
    parameter int DW    = 17,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_vld,
    input  logic [DW-1:0]            wr_dat,
    output logic                     wr_rdy,
    input  logic                     rd_en,
    output logic                     rd_vld,
    output logic [DW-1:0]            rd_dat,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = cnt_w(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

    // One extra pointer bit separates full (MSBs differ) from empty (equal).
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic [DW-1:0] mem_q [DEPTH];
    logic          push, pop;

    assign level  = wr_ptr_q - rd_ptr_q;
    assign wr_rdy = (level != FULL_LVL);
    assign rd_vld = (wr_ptr_q != rd_ptr_q);
    assign rd_dat = mem_q[rd_ptr_q[AW-1:0]];
    assign push   = wr_vld & wr_rdy;
    assign pop    = rd_en & rd_vld;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) wr_ptr_d = wr_ptr_q + (AW + 1)'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + (AW + 1)'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= wr_dat;
    end

endmodule

// File: rtl/spi_tft_stream_tx.sv
// Buffered SPI master (CPHA=0) for the TFT: per-word DC flag, CS held across back-to-back words.
// Latency: handshake in cycle N into an idle empty block drops SPI_CS with first bit at end of N+1.
// Backpressure: tx_ready = FIFO not full; words offered while full are ignored.
// Ports: SPI_CLK/reset, tx_data/tx_dc/tx_valid/tx_ready stream in, SPI_SCK/MOSI/CS/DC pins out,
//        busy, frame_done (pulse on first CS-high cycle), fifo_level.
module spi_tft_stream_tx
    import spi_tft_pkg::*;
#(
    parameter int   WIDTH      = 16,
    parameter int   FIFO_DEPTH = 4,
    parameter int   CLK_DIV    = 2,
    parameter logic CPOL       = 1'b0,
    parameter logic MSB_FIRST  = 1'b1
) (
    input  logic                          SPI_CLK,
    input  logic                          reset,
    input  logic [WIDTH-1:0]              tx_data,
    input  logic                          tx_dc,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          SPI_SCK,
    output logic                          SPI_MOSI,
    output logic                          SPI_CS,
    output logic                          SPI_DC,
    output logic                          busy,
    output logic                          frame_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int DIV_W = cnt_w(CLK_DIV);
    localparam int BIT_W = cnt_w(WIDTH);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);

    state_e             state_q, state_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic               sck_q, sck_d;
    logic               mosi_q, mosi_d;
    logic               cs_q, cs_d;
    logic               dc_q, dc_d;
    logic               fd_q, fd_d;

    logic               pop;
    logic               rd_vld;
    logic [WIDTH:0]     rd_dat;
    logic               div_wrap;
    logic [WIDTH-1:0]   shreg_nxt;

    spi_tft_fifo #(
        .DW    (WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (SPI_CLK),
        .reset  (reset),
        .wr_vld (tx_valid),
        .wr_dat ({tx_dc, tx_data}),
        .wr_rdy (tx_ready),
        .rd_en  (pop),
        .rd_vld (rd_vld),
        .rd_dat (rd_dat),
        .level  (fifo_level)
    );

    function automatic logic first_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    assign div_wrap  = (div_q == DIV_LAST);
    assign shreg_nxt = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0} : {1'b0, shreg_q[WIDTH-1:1]};

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        sck_d   = sck_q;
        mosi_d  = mosi_q;
        cs_d    = cs_q;
        dc_d    = dc_q;
        fd_d    = 1'b0;
        pop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cs_d  = 1'b1;
                sck_d = CPOL;
                div_d = '0;
                bit_d = '0;
                if (rd_vld) begin
                    pop     = 1'b1;
                    shreg_d = rd_dat[WIDTH-1:0];
                    dc_d    = rd_dat[WIDTH];
                    mosi_d  = first_bit(rd_dat[WIDTH-1:0]);
                    cs_d    = 1'b0;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (div_wrap) begin
                    div_d   = '0;
                    state_d = ST_SHIFT;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            ST_SHIFT: begin
                // Each bit spends one half-period at CPOL then one at ~CPOL, so a word
                // occupies exactly 2*WIDTH*CLK_DIV cycles and always ends at CPOL.
                if (!div_wrap) begin
                    div_d = div_q + DIV_W'(1);
                end else begin
                    div_d = '0;
                    if (sck_q == CPOL) begin
                        sck_d = ~CPOL;
                    end else begin
                        sck_d = CPOL;
                        if (bit_q != BIT_LAST) begin
                            bit_d   = bit_q + BIT_W'(1);
                            shreg_d = shreg_nxt;
                            mosi_d  = first_bit(shreg_nxt);
                        end else if (rd_vld) begin
                            // Chain the next word with CS held low and no gap.
                            pop     = 1'b1;
                            bit_d   = '0;
                            shreg_d = rd_dat[WIDTH-1:0];
                            dc_d    = rd_dat[WIDTH];
                            mosi_d  = first_bit(rd_dat[WIDTH-1:0]);
                        end else begin
                            state_d = ST_HOLD;
                        end
                    end
                end
            end
            ST_HOLD: begin
                if (div_wrap) begin
                    div_d   = '0;
                    cs_d    = 1'b1;
                    fd_d    = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge SPI_CLK) begin
        if (reset) begin
            state_q <= ST_IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            sck_q   <= CPOL;
            mosi_q  <= 1'b0;
            cs_q    <= 1'b1;
            dc_q    <= 1'b0;
            fd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            sck_q   <= sck_d;
            mosi_q  <= mosi_d;
            cs_q    <= cs_d;
            dc_q    <= dc_d;
            fd_q    <= fd_d;
        end
    end

    assign SPI_SCK    = sck_q;
    assign SPI_MOSI   = mosi_q;
    assign SPI_CS     = cs_q;
    assign SPI_DC     = dc_q;
    assign frame_done = fd_q;
    assign busy       = rd_vld | (state_q != ST_IDLE);

endmodule
